// File: rtl/tempd_stream_reader.sv
// tempd_stream_reader: sweeps a RAM address range and returns the
// words, in address order, on a valid/ready stream with backpressure.
module tempd_stream_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_BITS  = 11,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [ADDR_BITS:0]    length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_enable,
    output logic [ADDR_BITS-1:0]  mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = ADDR_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e                state_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [LW-1:0]         remain_q;
    logic [LW-1:0]         left_q;
    logic [CW-1:0]         os_q;
    logic [CW-1:0]         os_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         wptr_d;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         rptr_d;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
    logic                  pop;
    logic                  issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_FIN);
    assign out_valid        = (cnt_q != '0);
    assign out_data         = fifo_q[rptr_q];
    assign out_last         = out_valid && (left_q == LW'(1));
    assign mem_read_enable  = issue;
    assign mem_read_address = addr_q;

    // Handshake decode, read-issue gating and buffer/counter next state.
    always_comb begin
        pop    = out_valid && out_ready;
        issue  = (state_q == S_RUN) && (remain_q != '0)
                 && ((os_q < CW'(DEPTH)) || pop);
        os_d   = os_q + CW'(issue) - CW'(pop);
        cnt_d  = cnt_q + CW'(pend_q) - CW'(pop);
        wptr_d = pend_q ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    end

    // Job FSM, address/length counters and the output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            left_q   <= '0;
            os_q     <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            pend_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pend_q <= issue;
            os_q   <= os_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (pend_q) begin
                fifo_q[wptr_q] <= mem_read_data;
            end
            if (pop) begin
                left_q <= left_q - LW'(1);
            end
            if (issue) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - LW'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= length;
                        left_q   <= length;
                        state_q  <= (length == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue && remain_q == LW'(1)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && left_q == LW'(1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
